// File: rtl/motor_pkg.sv
// Shared definitions for the motor drive monitor: command width, default PWM
// period exponent and the per-side drive decision encoding.
package motor_pkg;

    localparam int MEAS_W          = 11;
    localparam int PERIOD_BITS_DEF = 10;

    typedef enum logic [2:0] {
        DRV_COAST,
        DRV_FWD,
        DRV_REV,
        DRV_BRAKE,
        DRV_ERR
    } drv_state_t;

endpackage

// File: rtl/pwm_chan_decode.sv
// One H-bridge side: registers both drive pins, counts their high time over a
// window and turns the final counts into a signed command plus brake/error flags.
module pwm_chan_decode
    import motor_pkg::*;
#(
    parameter int PERIOD_BITS = PERIOD_BITS_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fwd_i,
    input  logic              rev_i,
    input  logic              wcnt_term_i,
    input  logic              first_win_i,
    output logic [MEAS_W-1:0] meas_o,
    output logic              brk_o,
    output logic              err_o
);

    localparam int CW = PERIOD_BITS + 1;
    localparam logic [CW-1:0] N_CNT    = {1'b1, {PERIOD_BITS{1'b0}}};
    localparam logic [CW-1:0] MAX_DUTY = {1'b0, {PERIOD_BITS{1'b1}}};

    logic              fwd_q, rev_q;
    logic [CW-1:0]     fcnt_q, rcnt_q;
    logic [CW-1:0]     f_fin, r_fin, f_clip, r_clip;
    drv_state_t        state_d;
    logic [MEAS_W-1:0] meas_q, meas_d;
    logic              brk_q, brk_d;
    logic              err_q, err_d;

    // Final counts include the sample being added on the terminal cycle.
    always_comb begin
        f_fin  = fcnt_q + {{PERIOD_BITS{1'b0}}, fwd_q};
        r_fin  = rcnt_q + {{PERIOD_BITS{1'b0}}, rev_q};
        f_clip = (f_fin > MAX_DUTY) ? MAX_DUTY : f_fin;
        r_clip = (r_fin > MAX_DUTY) ? MAX_DUTY : r_fin;

        if (f_fin == N_CNT && r_fin == N_CNT) begin
            state_d = DRV_BRAKE;
        end else if (f_fin == '0 && r_fin == '0) begin
            state_d = DRV_COAST;
        end else if (r_fin == '0) begin
            state_d = DRV_FWD;
        end else if (f_fin == '0) begin
            state_d = DRV_REV;
        end else begin
            state_d = DRV_ERR;
        end

        meas_d = meas_q;
        brk_d  = 1'b0;
        err_d  = 1'b0;
        case (state_d)
            DRV_BRAKE: begin
                brk_d  = 1'b1;
                meas_d = '0;
            end
            DRV_COAST: meas_d = '0;
            DRV_FWD:   meas_d = MEAS_W'(f_clip);
            DRV_REV:   meas_d = '0 - MEAS_W'(r_clip);
            default:   err_d  = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_q  <= 1'b0;
            rev_q  <= 1'b0;
            fcnt_q <= '0;
            rcnt_q <= '0;
            meas_q <= '0;
            brk_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            fwd_q <= fwd_i;
            rev_q <= rev_i;
            if (wcnt_term_i) begin
                fcnt_q <= '0;
                rcnt_q <= '0;
                if (!first_win_i) begin
                    meas_q <= meas_d;
                    brk_q  <= brk_d;
                    err_q  <= err_d;
                end
            end else begin
                fcnt_q <= f_fin;
                rcnt_q <= r_fin;
            end
        end
    end

    assign meas_o = meas_q;
    assign brk_o  = brk_q;
    assign err_o  = err_q;

endmodule

// File: rtl/motor_cntrl_mon.sv
// Passive monitor of the four H-bridge drive pins; owns the shared measurement
// window, discards the first window after reset and pulses meas_vld per window.
module motor_cntrl_mon
    import motor_pkg::*;
#(
    parameter int PERIOD_BITS = PERIOD_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fwd_lft,
    input  logic              rev_lft,
    input  logic              fwd_rht,
    input  logic              rev_rht,
    output logic [MEAS_W-1:0] lft_meas,
    output logic [MEAS_W-1:0] rht_meas,
    output logic              brk_lft,
    output logic              brk_rht,
    output logic              err_lft,
    output logic              err_rht,
    output logic              meas_vld
);

    logic [PERIOD_BITS-1:0] wcnt_q;
    logic                   first_win_q;
    logic                   meas_vld_q;
    logic                   wcnt_term;

    assign wcnt_term = &wcnt_q;

    // The first window after reset may start mid-pulse of the driver, so it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q      <= '0;
            first_win_q <= 1'b1;
            meas_vld_q  <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_q + 1'b1;
            meas_vld_q <= wcnt_term && !first_win_q;
            if (wcnt_term) begin
                first_win_q <= 1'b0;
            end
        end
    end

    assign meas_vld = meas_vld_q;

    pwm_chan_decode #(
        .PERIOD_BITS(PERIOD_BITS)
    ) u_lft (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .fwd_i       (fwd_lft),
        .rev_i       (rev_lft),
        .wcnt_term_i (wcnt_term),
        .first_win_i (first_win_q),
        .meas_o      (lft_meas),
        .brk_o       (brk_lft),
        .err_o       (err_lft)
    );

    pwm_chan_decode #(
        .PERIOD_BITS(PERIOD_BITS)
    ) u_rht (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .fwd_i       (fwd_rht),
        .rev_i       (rev_rht),
        .wcnt_term_i (wcnt_term),
        .first_win_i (first_win_q),
        .meas_o      (rht_meas),
        .brk_o       (brk_rht),
        .err_o       (err_rht)
    );

endmodule

// File: tb/tb_motor_cntrl_mon.sv
// Bench for motor_cntrl_mon: a 16-cycle-window instance for the per-feature
// scenarios and a 1024-cycle-window instance fed by a fixed PWM pattern.
module tb_motor_cntrl_mon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fwd_lft = 1'b0, rev_lft = 1'b0, fwd_rht = 1'b0, rev_rht = 1'b0;
    logic [10:0] lft_meas, rht_meas;
    logic        brk_lft, brk_rht, err_lft, err_rht, meas_vld;

    logic        b_fwd_lft = 1'b0, b_rev_lft = 1'b0, b_fwd_rht = 1'b0, b_rev_rht = 1'b0;
    logic [10:0] b_lft_meas, b_rht_meas;
    logic        b_brk_lft, b_brk_rht, b_err_lft, b_err_rht, b_meas_vld;

    int          errors = 0;
    int          checks = 0;
    int          tc = 0;
    int          d_fl = 0, d_rl = 0, d_fr = 0, d_rr = 0;
    int          ph_l = 0, ph_r = 0;
    logic [10:0] prev_l = '0, prev_r = '0;
    logic [25:0] exp_q[$];

    always #5 clk = ~clk;

    motor_cntrl_mon #(.PERIOD_BITS(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fwd_lft(fwd_lft), .rev_lft(rev_lft), .fwd_rht(fwd_rht), .rev_rht(rev_rht),
        .lft_meas(lft_meas), .rht_meas(rht_meas),
        .brk_lft(brk_lft), .brk_rht(brk_rht),
        .err_lft(err_lft), .err_rht(err_rht),
        .meas_vld(meas_vld)
    );

    motor_cntrl_mon #(.PERIOD_BITS(10)) u_big (
        .clk(clk), .rst_n(rst_n),
        .fwd_lft(b_fwd_lft), .rev_lft(b_rev_lft), .fwd_rht(b_fwd_rht), .rev_rht(b_rev_rht),
        .lft_meas(b_lft_meas), .rht_meas(b_rht_meas),
        .brk_lft(b_brk_lft), .brk_rht(b_brk_rht),
        .err_lft(b_err_lft), .err_rht(b_err_rht),
        .meas_vld(b_meas_vld)
    );

    // Expected {err, brk, meas} for one side with N = 16, from high counts f and r.
    function automatic logic [12:0] model_side(int f, int r, logic [10:0] prev);
        int m;
        if (f == 16 && r == 16) return {1'b0, 1'b1, 11'd0};
        if (f == 0 && r == 0) return 13'd0;
        if (r == 0) begin
            m = (f > 15) ? 15 : f;
            return {2'b00, 11'(m)};
        end
        if (f == 0) begin
            m = (r > 15) ? 15 : r;
            return {2'b00, 11'(-m)};
        end
        return {1'b1, 1'b0, prev};
    endfunction

    task automatic step();
        @(negedge clk);
        tc++;
        fwd_lft   = (((tc + ph_l) % 16) < d_fl);
        rev_lft   = (((tc + ph_l) % 16) < d_rl);
        fwd_rht   = (((tc + ph_r) % 16) < d_fr);
        rev_rht   = (((tc + ph_r) % 16) < d_rr);
        b_fwd_lft = ((tc % 1024) < 300);
        b_rev_lft = 1'b0;
        b_fwd_rht = 1'b0;
        b_rev_rht = ((tc % 1024) < 512);
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (meas_vld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_pattern(int fl, int rl, int fr, int rr);
        d_fl = fl; d_rl = rl; d_fr = fr; d_rr = rr;
        ph_l = $urandom_range(0, 15);
        ph_r = $urandom_range(0, 15);
    endtask

    // Drops the window blended by the pattern change, queues the expectation,
    // and stops on the vld pulse of the first fully clean window.
    task automatic run_window(output bit ok);
        logic [12:0] el, er;
        wait_vld(ok);
        if (!ok) return;
        el = model_side(d_fl, d_rl, prev_l);
        er = model_side(d_fr, d_rr, prev_r);
        prev_l = el[10:0];
        prev_r = er[10:0];
        exp_q.push_back({el, er});
        wait_vld(ok);
    endtask

    task automatic test_reset();
        int first;
        logic [25:0] exp;
        set_pattern(0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (lft_meas !== 11'd0 || rht_meas !== 11'd0) begin
            errors++;
            $display("FAIL reset_meas: lft=%h rht=%h required 0/0", lft_meas, rht_meas);
        end
        checks++;
        if ({brk_lft, brk_rht, err_lft, err_rht} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: brk/err=%b required 0000", {brk_lft, brk_rht, err_lft, err_rht});
        end
        checks++;
        if (meas_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: meas_vld=%b required 0", meas_vld);
        end
        rst_n = 1'b1;
        exp_q.push_back(26'd0);
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (meas_vld) begin
                first = k;
                break;
            end
        end
        checks++;
        if (first != 32) begin
            errors++;
            $display("FAIL reset_first_vld: cycles=%0d required 32", first);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas} !== exp) begin
            errors++;
            $display("FAIL reset_first_value: got %h required %h",
                     {err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas}, exp);
        end
    endtask

    task automatic test_forward();
        int duties[2] = '{5, 15};
        bit ok;
        logic [25:0] exp;
        foreach (duties[i]) begin
            set_pattern(duties[i], 0, 0, 0);
            run_window(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL forward_%0d: meas_vld timeout required pulse", duties[i]);
            end else begin
                exp = exp_q.pop_front();
                if ({err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas} !== exp) begin
                    errors++;
                    $display("FAIL forward_%0d: got %h required %h", duties[i],
                             {err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas}, exp);
                end
            end
        end
    endtask

    task automatic test_reverse();
        int duties[2] = '{9, 16};
        bit ok;
        logic [25:0] exp;
        foreach (duties[i]) begin
            set_pattern(0, 0, 0, duties[i]);
            run_window(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL reverse_%0d: meas_vld timeout required pulse", duties[i]);
            end else begin
                exp = exp_q.pop_front();
                if ({err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas} !== exp) begin
                    errors++;
                    $display("FAIL reverse_%0d: got %h required %h", duties[i],
                             {err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas}, exp);
                end
            end
        end
    endtask

    task automatic test_brake_err();
        bit ok;
        logic [25:0] exp;
        set_pattern(16, 16, 0, 0);
        run_window(ok);
        checks++;
        exp = ok ? exp_q.pop_front() : 26'd0;
        if (!ok || {err_lft, brk_lft, lft_meas} !== exp[25:13]) begin
            errors++;
            $display("FAIL brake: ok=%0d got %h required %h", ok, {err_lft, brk_lft, lft_meas}, exp[25:13]);
        end
        set_pattern(8, 8, 0, 0);
        run_window(ok);
        checks++;
        exp = ok ? exp_q.pop_front() : 26'd0;
        if (!ok || {err_lft, brk_lft, lft_meas} !== exp[25:13]) begin
            errors++;
            $display("FAIL error_hold: ok=%0d got %h required %h", ok, {err_lft, brk_lft, lft_meas}, exp[25:13]);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int first;
        logic [25:0] exp;
        set_pattern(5, 0, 0, 7);
        run_window(ok);
        checks++;
        exp = ok ? exp_q.pop_front() : 26'd0;
        if (!ok || {err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas} !== exp) begin
            errors++;
            $display("FAIL mid_pre: ok=%0d got %h required %h", ok,
                     {err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas}, exp);
        end
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas, meas_vld} !== 27'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: got %h required 0",
                     {err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas, meas_vld});
        end
        prev_l = '0;
        prev_r = '0;
        repeat (2) step();
        rst_n = 1'b1;
        exp_q.push_back({model_side(d_fl, d_rl, prev_l), model_side(d_fr, d_rr, prev_r)});
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (meas_vld) begin
                first = k;
                break;
            end
        end
        checks++;
        if (first != 32) begin
            errors++;
            $display("FAIL mid_reset_first_vld: cycles=%0d required 32", first);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas} !== exp) begin
            errors++;
            $display("FAIL mid_reset_value: got %h required %h",
                     {err_lft, brk_lft, lft_meas, err_rht, brk_rht, rht_meas}, exp);
        end
    endtask

    task automatic test_loopback();
        int n = 0;
        bit err_seen = 1'b0;
        logic [10:0] got_l = '0, got_r = '0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (b_meas_vld) begin
                n++;
                if (b_err_lft || b_err_rht) err_seen = 1'b1;
                if (n == 2) begin
                    got_l = b_lft_meas;
                    got_r = b_rht_meas;
                    break;
                end
            end
        end
        checks++;
        if (n < 2 || got_l !== 11'd300) begin
            errors++;
            $display("FAIL loop_lft: vlds=%0d lft=%0d required 300", n, got_l);
        end
        checks++;
        if (n < 2 || got_r !== 11'h600) begin
            errors++;
            $display("FAIL loop_rht: vlds=%0d rht=%h required 600", n, got_r);
        end
        checks++;
        if (err_seen) begin
            errors++;
            $display("FAIL loop_err: err seen=1 required 0");
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_brake_err();
        test_mid_reset();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
